// File: rtl/readout_frame_receiver.sv
// readout_frame_receiver
//
// Receiving end of the AE serial readout link. Deserializes the frames sent by
// the readout FSM: a RTC_W-bit timestamp (ser_sel=0) followed by any number of
// WORD_W-bit channel-memory words (ser_sel=1), all inside one ser_frame
// envelope, MSB first. Timestamp and words are handed to host logic as
// single-cycle strobes, with a per-frame word count and sticky protocol errors.
//
// Optional feature: define RX_TIMEOUT_EN to enable the in-frame idle timeout
// (parameter TIMEOUT_CYC, err_flags[3]). Without it, a frame may idle forever
// and err_flags[3] is tied to 0.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   ser_frame    frame envelope
//   ser_sel      field select: 0 = RTC, 1 = memory data
//   ser_valid    bit strobe qualifying ser_data (ignored while ser_frame=0)
//   ser_data     serial bit, MSB first
//   rtc_value    last complete timestamp, held until the next one
//   rtc_valid    1-cycle pulse, rtc_value updated
//   word_data    last complete word
//   word_idx     position of word_data within its bank, 0..BANK_WORDS-1
//   word_bank    toggles on each word_idx wrap, starts at 0 every frame
//   word_valid   1-cycle pulse, word_data/word_idx/word_bank updated
//   frame_words  words received in the last frame, saturating at 16'hFFFF
//   frame_done   1-cycle pulse, frame closed normally
//   err_flags    sticky, cleared at next frame start
//                [0] RTC short, [1] field order, [2] partial word, [3] timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for ser_frame; a bit in the start cycle is RTC bit 0
// RTC   | shifting in the timestamp field
// DATA  | shifting in memory words until ser_frame drops
// DRAIN | protocol error seen, ignore everything until ser_frame drops

module readout_frame_receiver #(
  parameter int RTC_W      = 30,
  parameter int WORD_W     = 16,
  parameter int BANK_WORDS = 200
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_frame,
  input  logic              ser_sel,
  input  logic              ser_valid,
  input  logic              ser_data,
  output logic [RTC_W-1:0]  rtc_value,
  output logic              rtc_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [8:0]        word_idx,
  output logic              word_bank,
  output logic              word_valid,
  output logic [15:0]       frame_words,
  output logic              frame_done,
  output logic [3:0]        err_flags
);

  localparam int CNT_W = $clog2((RTC_W > WORD_W) ? RTC_W : WORD_W) + 1;
  localparam logic [CNT_W-1:0] RTC_LAST  = CNT_W'(RTC_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [8:0]       IDX_LAST  = 9'(BANK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RTC,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  cnt_eff;
  logic [RTC_W-2:0]  rtc_shift_q;
  logic [WORD_W-2:0] word_shift_q;
  logic [8:0]        idx_cnt_q;
  logic              bank_q;

  logic       frame_start;
  logic       rtc_bit;
  logic       rtc_done;
  logic       word_bit;
  logic       word_done;
  logic       frame_close;
  logic [3:0] err_set;
  logic       timeout_hit;

  // The start cycle can already carry RTC bit 0, and bit_cnt still holds
  // leftovers from a previous frame at that point, so count from zero there.
  assign cnt_eff = (state_q == S_IDLE) ? '0 : bit_cnt_q;

`ifdef RX_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYC - 1);

  logic [15:0] idle_cnt_q;
  logic        in_field;

  assign in_field    = (state_q == S_RTC) || (state_q == S_DATA);
  assign timeout_hit = in_field && (idle_cnt_q == 16'd0);

  // Down-counter reloaded by every accepted bit; terminal count 0 means
  // TIMEOUT_CYC consecutive cycles went by without a bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= TO_LOAD;
    end else if (frame_start || rtc_bit || word_bit || !in_field) begin
      idle_cnt_q <= TO_LOAD;
    end else if (idle_cnt_q != 16'd0) begin
      idle_cnt_q <= idle_cnt_q - 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    rtc_bit     = 1'b0;
    rtc_done    = 1'b0;
    word_bit    = 1'b0;
    word_done   = 1'b0;
    frame_close = 1'b0;
    err_set     = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (ser_frame) begin
          frame_start = 1'b1;
          state_d     = S_RTC;
        end
      end
      S_RTC: begin
        if (!ser_frame) begin
          err_set[0] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_DATA: begin
        if (!ser_frame) begin
          frame_close = 1'b1;
          if (bit_cnt_q != '0) begin
            err_set[2] = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!ser_frame) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timestamp field: start cycle of IDLE or inside RTC.
    if (ser_frame && ((state_q == S_IDLE) || (state_q == S_RTC))) begin
      if (ser_valid) begin
        if (!ser_sel) begin
          rtc_bit = 1'b1;
          if (cnt_eff == RTC_LAST) begin
            rtc_done = 1'b1;
            state_d  = S_DATA;
          end
        end else begin
          err_set[0] = 1'b1;
          state_d    = S_DRAIN;
        end
      end else if (timeout_hit) begin
        err_set[3] = 1'b1;
        state_d    = S_DRAIN;
      end
    end

    // Memory-word field.
    if (ser_frame && (state_q == S_DATA)) begin
      if (ser_valid) begin
        if (ser_sel) begin
          word_bit = 1'b1;
          if (bit_cnt_q == WORD_LAST) begin
            word_done = 1'b1;
          end
        end else begin
          err_set[1] = 1'b1;
          state_d    = S_DRAIN;
        end
      end else if (timeout_hit) begin
        err_set[3] = 1'b1;
        state_d    = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      rtc_shift_q  <= '0;
      word_shift_q <= '0;
      idx_cnt_q    <= '0;
      bank_q       <= 1'b0;
      rtc_value    <= '0;
      rtc_valid    <= 1'b0;
      word_data    <= '0;
      word_idx     <= '0;
      word_bank    <= 1'b0;
      word_valid   <= 1'b0;
      frame_words  <= '0;
      frame_done   <= 1'b0;
      err_flags    <= '0;
    end else begin
      rtc_valid  <= rtc_done;
      word_valid <= word_done;
      frame_done <= frame_close;
      err_flags  <= (frame_start ? 4'b0000 : err_flags) | err_set;

      if (rtc_done || word_done) begin
        bit_cnt_q <= '0;
      end else if (rtc_bit || word_bit) begin
        bit_cnt_q <= cnt_eff + CNT_W'(1);
      end else if (frame_start) begin
        bit_cnt_q <= '0;
      end

      if (rtc_bit) begin
        rtc_shift_q <= {rtc_shift_q[RTC_W-3:0], ser_data};
      end
      if (rtc_done) begin
        rtc_value <= {rtc_shift_q, ser_data};
      end

      if (word_bit) begin
        word_shift_q <= {word_shift_q[WORD_W-3:0], ser_data};
      end

      if (frame_start) begin
        idx_cnt_q   <= '0;
        bank_q      <= 1'b0;
        frame_words <= '0;
      end else if (word_done) begin
        word_data <= {word_shift_q, ser_data};
        word_idx  <= idx_cnt_q;
        word_bank <= bank_q;
        if (idx_cnt_q == IDX_LAST) begin
          idx_cnt_q <= '0;
          bank_q    <= ~bank_q;
        end else begin
          idx_cnt_q <= idx_cnt_q + 9'd1;
        end
        if (frame_words != 16'hFFFF) begin
          frame_words <= frame_words + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_readout_frame_receiver.sv
// Self-checking bench for readout_frame_receiver: directed frames plus
// randomized frames (random payloads, gaps and protocol errors) checked against
// expectation queues derived from the frame content.
module tb_readout_frame_receiver;

  localparam int RTC_W      = 30;
  localparam int WORD_W     = 16;
  localparam int BANK_WORDS = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              ser_frame, ser_sel, ser_valid, ser_data;
  logic [RTC_W-1:0]  rtc_value;
  logic              rtc_valid;
  logic [WORD_W-1:0] word_data;
  logic [8:0]        word_idx;
  logic              word_bank;
  logic              word_valid;
  logic [15:0]       frame_words;
  logic              frame_done;
  logic [3:0]        err_flags;

  readout_frame_receiver dut (
    .clk(clk), .reset(reset),
    .ser_frame(ser_frame), .ser_sel(ser_sel), .ser_valid(ser_valid), .ser_data(ser_data),
    .rtc_value(rtc_value), .rtc_valid(rtc_valid),
    .word_data(word_data), .word_idx(word_idx), .word_bank(word_bank), .word_valid(word_valid),
    .frame_words(frame_words), .frame_done(frame_done), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gap_pct = 0;

  logic [29:0] exp_rtc[$];
  logic [25:0] exp_word[$];
  logic [15:0] exp_fw[$];
  logic [15:0] word_src[$];

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rtc_valid) begin
        if (exp_rtc.size() == 0) chk("rtc_unexpected", 80'(rtc_valid), 80'(0));
        else chk("rtc_value", 80'(rtc_value), 80'(exp_rtc.pop_front()));
      end
      if (word_valid) begin
        if (exp_word.size() == 0) chk("word_unexpected", 80'(word_valid), 80'(0));
        else chk("word_bank_idx_data", 80'({word_bank, word_idx, word_data}),
                 80'(exp_word.pop_front()));
      end
      if (frame_done) begin
        if (exp_fw.size() == 0) chk("frame_done_unexpected", 80'(frame_done), 80'(0));
        else chk("frame_words", 80'(frame_words), 80'(exp_fw.pop_front()));
      end
    end
  end

  task automatic cyc(input logic f, input logic s, input logic v, input logic d);
    ser_frame = f; ser_sel = s; ser_valid = v; ser_data = d;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic s, input logic d);
    while ($urandom_range(99) < gap_pct) cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom));
    cyc(1'b1, s, 1'b1, d);
  endtask

  // mode 0: clean frame, 'tail' partial bits before close
  // mode 1: ser_sel=1 after p RTC bits, then 'tail' junk cycles
  // mode 2: nw words + tail bits, then a sel=0 bit and junk
  // mode 3: ser_frame drops after p RTC bits
  task automatic run_frame(input int mode, input logic [29:0] rtc, input int nw,
                           input int p, input int tail, input bit long_gap);
    logic [3:0]  exp_err;
    logic [15:0] w;
    bit          timed_out;
    exp_err   = 4'b0000;
    timed_out = 1'b0;
    if (mode == 1 || mode == 3) begin
      for (int i = 0; i < p; i++) send_bit(1'b0, rtc[29-i]);
      if (mode == 1) begin
        send_bit(1'b1, 1'($urandom));
        for (int i = 0; i < tail; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      exp_err = 4'b0001;
    end else begin
      exp_rtc.push_back(rtc);
      for (int i = 0; i < RTC_W; i++) send_bit(1'b0, rtc[29-i]);
      if (long_gap) begin
        repeat (1100) cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom));
`ifdef RX_TIMEOUT_EN
        timed_out = 1'b1;
        exp_err   = 4'b1000;
`endif
      end
      if (timed_out) begin
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        for (int k = 0; k < nw; k++) begin
          w = (word_src.size() != 0) ? word_src.pop_front() : 16'($urandom);
          exp_word.push_back({1'((k / BANK_WORDS) % 2), 9'(k % BANK_WORDS), w});
          for (int b = 0; b < WORD_W; b++) send_bit(1'b1, w[15-b]);
        end
        for (int b = 0; b < tail; b++) send_bit(1'b1, 1'($urandom));
        if (mode == 2) begin
          send_bit(1'b0, 1'($urandom));
          for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
          exp_err = 4'b0010;
        end else begin
          exp_fw.push_back(16'(nw));
          if (tail > 0) exp_err = 4'b0100;
        end
      end
    end
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("err_flags", 80'(err_flags), 80'(exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 80'({rtc_value, rtc_valid, word_data, word_idx, word_bank, word_valid,
                  frame_words, frame_done, err_flags}), 80'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int mode, p, nw, tail;
    reset = 1'b1;
    ser_frame = 1'b0; ser_sel = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Directed: timestamp and three known words.
    gap_pct = 0;
    word_src.push_back(16'h1234);
    word_src.push_back(16'hBEEF);
    word_src.push_back(16'h0001);
    run_frame(0, 30'h2ABCDEF1, 3, 0, 0, 1'b0);

    // Long frame across two bank wraps, full rate.
    run_frame(0, 30'h0000_0001, 450, 0, 0, 1'b0);

    // Sel flips after 12 RTC bits, then a clean frame.
    run_frame(1, 30'h1555_5555, 0, 12, 5, 1'b0);
    run_frame(0, 30'h3FFF_FFFF, 2, 0, 0, 1'b0);

    // Frame drops after 2 words + 7 bits.
    run_frame(0, 30'h0123_4567, 2, 0, 7, 1'b0);

    // Field-order error inside DATA.
    run_frame(2, 30'h2222_1111, 3, 0, 4, 1'b0);

    // Zero-word frame.
    run_frame(0, 30'h0BAD_CAFE, 0, 0, 0, 1'b0);

    // Long idle gap inside DATA.
    run_frame(0, 30'h1357_9BDF, 2, 0, 0, 1'b1);

    // Reset asserted mid-word, then a clean frame.
    exp_rtc.push_back(30'h2468_ACE0);
    for (int i = 0; i < RTC_W; i++) send_bit(1'b0, 1'(30'h2468_ACE0 >> (29 - i)));
    w = 16'hA5C3;
    exp_word.push_back({1'b0, 9'd0, w});
    for (int b = 0; b < WORD_W; b++) send_bit(1'b1, w[15-b]);
    for (int b = 0; b < 5; b++) send_bit(1'b1, 1'($urandom));
    ser_frame = 1'b0;
    reset = 1'b1;
    #1;
    chk_all_zero("reset_mid_word");
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 30'h1ACE_0F0F, 4, 0, 0, 1'b0);

    // Randomized frames with gaps and errors, back-to-back.
    for (int f = 0; f < 40; f++) begin
      gap_pct = $urandom_range(30);
      mode = $urandom_range(3);
      p    = (mode == 3) ? $urandom_range(29, 1) : $urandom_range(29);
      nw   = $urandom_range(20);
      tail = ($urandom_range(1) == 0) ? 0 : $urandom_range(15, 1);
      run_frame(mode, 30'($urandom), nw, p, tail, 1'b0);
      repeat ($urandom_range(2)) cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rtc_pending", 80'(exp_rtc.size()), 80'(0));
    chk("word_pending", 80'(exp_word.size()), 80'(0));
    chk("frame_done_pending", 80'(exp_fw.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
